// File: rtl/pipeline_pkg.sv
// Shared pipeline package: decoded-instruction record, register-address width
// and the per-instruction classification helpers used by the issue stage.
package pipeline;

   localparam int REG_W    = 5;
   localparam int NUM_REGS = 32;

   typedef logic [REG_W-1:0] reg_t;

   typedef struct packed {
      logic [31:0]           pc;
      reg_t                  w_reg;
      logic [1:0][REG_W-1:0] r_reg;
      logic                  need_csr;
      logic                  invalid_inst;
      logic                  need_mul;
      logic                  need_div;
      logic                  need_bpu;
      logic                  need_lsu;
      logic                  mem_write;
      logic                  mem_cacop;
   } inst_t;

   // One-hot register bit; register 0 maps to an empty mask so it never conflicts.
   function automatic logic [NUM_REGS-1:0] reg_mask(input reg_t r);
      logic [NUM_REGS-1:0] m;
      m    = {NUM_REGS{1'b0}};
      m[r] = (r != {REG_W{1'b0}});
      return m;
   endfunction

   function automatic logic [NUM_REGS-1:0] uses_mask(input inst_t i);
      return reg_mask(i.w_reg) | reg_mask(i.r_reg[0]) | reg_mask(i.r_reg[1]);
   endfunction

   function automatic logic is_long_lat(input inst_t i);
      logic is_load;
      is_load = i.need_lsu && !i.mem_write && !i.mem_cacop;
      return (is_load || i.need_mul || i.need_div) && (i.w_reg != {REG_W{1'b0}});
   endfunction

   function automatic logic is_serial(input inst_t i);
      return i.need_csr || i.invalid_inst;
   endfunction

   function automatic logic is_lsu_excl(input inst_t i);
      return i.mem_write || i.mem_cacop;
   endfunction

   // Conflict between an older group member and a younger one.
   function automatic logic pair_conflict(input inst_t o, input inst_t y);
      logic data_c;
      logic unit_c;
      logic lsu_c;
      data_c = (reg_mask(o.w_reg) & uses_mask(y)) != {NUM_REGS{1'b0}};
      unit_c = (o.need_mul && y.need_mul) || (o.need_div && y.need_div) ||
               (o.need_bpu && y.need_bpu);
      lsu_c  = (is_lsu_excl(o) && y.need_lsu) || (is_lsu_excl(y) && o.need_lsu);
      return data_c || unit_c || lsu_c;
   endfunction

   function automatic logic sb_blocked(input inst_t i, input logic [NUM_REGS-1:0] pend);
      return (uses_mask(i) & pend) != {NUM_REGS{1'b0}};
   endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-writeback scoreboard for long-latency producers. Exposes the
// effective pending vector (stored bits minus same-cycle writebacks).
module issue_scoreboard
   import pipeline::*;
#(
   parameter int ISSUE_WIDTH = 2,
   parameter int WB_PORTS    = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic [ISSUE_WIDTH-1:0]            set_valid,
   input  logic [ISSUE_WIDTH-1:0][REG_W-1:0] set_reg,
   input  logic [WB_PORTS-1:0]               wb_valid,
   input  logic [WB_PORTS-1:0][REG_W-1:0]    wb_reg,
   output logic [NUM_REGS-1:0]               pending
);

   logic [NUM_REGS-1:0] pend_r;
   logic [NUM_REGS-1:0] set_s;
   logic [NUM_REGS-1:0] clr_s;

   always_comb begin
      set_s = {NUM_REGS{1'b0}};
      clr_s = {NUM_REGS{1'b0}};
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         set_s = set_s | (set_valid[k] ? reg_mask(set_reg[k]) : {NUM_REGS{1'b0}});
      end
      for (int p = 0; p < WB_PORTS; p++) begin
         clr_s = clr_s | (wb_valid[p] ? reg_mask(wb_reg[p]) : {NUM_REGS{1'b0}});
      end
   end

   assign pending = pend_r & ~clr_s;

   // Set is applied after clear: a new producer supersedes the one writing back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r <= {NUM_REGS{1'b0}};
      end else if (flush) begin
         pend_r <= {NUM_REGS{1'b0}};
      end else begin
         pend_r <= (pend_r & ~clr_s) | set_s;
      end
   end

endmodule

// File: rtl/issue_queue.sv
// In-order multi-issue queue between decode and execute. Define
// ISSUE_SCOREBOARD_EN to add the long-latency RAW/WAW scoreboard.
module issue_queue
   import pipeline::*;
#(
   parameter int ISSUE_WIDTH = 2,
   parameter int BUF_DEPTH   = 8,
   parameter int WB_PORTS    = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush_i,
   input  inst_t                          inst_i [ISSUE_WIDTH],
   input  logic [ISSUE_WIDTH-1:0]         d_valid_i,
   output logic                           d_ready_o,
   input  logic                           ex_ready_i,
   output inst_t                          is_inst_o [ISSUE_WIDTH],
   output logic [ISSUE_WIDTH-1:0]         is_o,
   output logic                           ex_valid_o,
   input  logic [WB_PORTS-1:0]            wb_valid_i,
   input  logic [WB_PORTS-1:0][REG_W-1:0] wb_reg_i
);

   localparam int IDX_W = $clog2(BUF_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = IDX_W + 1;

   logic [PTR_W-1:0]                  head_r;
   logic [PTR_W-1:0]                  tail_r;
   logic [CNT_W-1:0]                  count_r;
   inst_t                             mem_r [BUF_DEPTH];
   inst_t                             cand_s [ISSUE_WIDTH];
   logic [CNT_W-1:0]                  enq_cnt_s;
   logic [CNT_W-1:0]                  iss_cnt_s;
   logic                              enq_en_s;
   logic [ISSUE_WIDTH-1:0]            iss_s;
   logic [ISSUE_WIDTH-1:0]            set_valid_s;
   logic [ISSUE_WIDTH-1:0][REG_W-1:0] set_reg_s;
   logic [NUM_REGS-1:0]               pend_eff_s;

   assign d_ready_o  = (count_r <= CNT_W'(BUF_DEPTH - ISSUE_WIDTH));
   assign ex_valid_o = (count_r != {CNT_W{1'b0}});
   assign enq_en_s   = d_ready_o && !flush_i;
   assign is_o       = iss_s;
   assign is_inst_o  = cand_s;

   // Head-relative candidate window; the index wraps naturally at BUF_DEPTH.
   always_comb begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         cand_s[k] = mem_r[head_r[IDX_W-1:0] + IDX_W'(k)];
      end
   end

   always_comb begin
      enq_cnt_s = {CNT_W{1'b0}};
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         enq_cnt_s = enq_cnt_s + CNT_W'(enq_en_s && d_valid_i[k]);
      end
   end

   // Longest legal in-order prefix: each slot needs every older slot to issue.
   always_comb begin
      logic chain;
      logic ok;
      iss_s       = {ISSUE_WIDTH{1'b0}};
      iss_cnt_s   = {CNT_W{1'b0}};
      set_valid_s = {ISSUE_WIDTH{1'b0}};
      set_reg_s   = {(ISSUE_WIDTH*REG_W){1'b0}};
      chain       = ex_ready_i && !flush_i;
      ok          = 1'b0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         ok = chain && (CNT_W'(k) < count_r) && !sb_blocked(cand_s[k], pend_eff_s) &&
              !((k != 0) && is_serial(cand_s[k]));
         for (int j = 0; j < ISSUE_WIDTH; j++) begin
            ok = ok && !((j < k) && (is_serial(cand_s[j]) || pair_conflict(cand_s[j], cand_s[k])));
         end
         iss_s[k]       = ok;
         chain          = ok;
         iss_cnt_s      = iss_cnt_s + CNT_W'(ok);
         set_valid_s[k] = ok && is_long_lat(cand_s[k]);
         set_reg_s[k]   = cand_s[k].w_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (flush_i) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         head_r  <= head_r + PTR_W'(iss_cnt_s);
         tail_r  <= tail_r + PTR_W'(enq_cnt_s);
         count_r <= count_r + enq_cnt_s - iss_cnt_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < BUF_DEPTH; e++) begin
            mem_r[e] <= '0;
         end
      end else begin
         for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (enq_en_s && d_valid_i[k]) begin
               mem_r[tail_r[IDX_W-1:0] + IDX_W'(k)] <= inst_i[k];
            end
         end
      end
   end

`ifdef ISSUE_SCOREBOARD_EN
   issue_scoreboard #(
      .ISSUE_WIDTH (ISSUE_WIDTH),
      .WB_PORTS    (WB_PORTS)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_i),
      .set_valid (set_valid_s),
      .set_reg   (set_reg_s),
      .wb_valid  (wb_valid_i),
      .wb_reg    (wb_reg_i),
      .pending   (pend_eff_s)
   );
`else
   // Without the scoreboard, long-latency hazards are interlocked downstream.
   logic unused_wb_s;
   assign unused_wb_s = ^{wb_valid_i, wb_reg_i, set_valid_s, set_reg_s};
   assign pend_eff_s  = {NUM_REGS{1'b0}};
`endif

endmodule
